// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller:
// FSM state encoding and the comparator-flag one-hot check.
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } sar_state_t;

  // Bits of {gt, lt, eq} that take part in the one-hot check.
  localparam logic [2:0] FLAG_ONEHOT_MASK = 3'b111;

  function automatic logic flags_onehot(input logic [2:0] flags);
    logic [2:0] masked;
    masked = flags & FLAG_ONEHOT_MASK;
    case (masked)
      3'b001, 3'b010, 3'b100: flags_onehot = 1'b1;
      default:                flags_onehot = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Bundle between the search controller and its environment: start/status
// towards the host, trial value and flags towards the magnitude comparator.
interface sar_search_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_err;

  modport master (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  trial, busy, done, result, flag_err
  );

  modport slave (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output trial, busy, done, result, flag_err
  );
endinterface

// File: rtl/sar_wait_timer.sv
// Settling down-counter that covers the comparator latency; with CMP_LAT = 0
// it collapses to a constant "expired".
module sar_wait_timer #(
  parameter int CMP_LAT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [1:0] value,
  output logic       expired
);

  generate
    if (CMP_LAT == 0) begin : g_no_wait
      logic unused_s;
      assign unused_s = ^{clk, rst, load, value};
      assign expired  = 1'b1;
    end else begin : g_wait
      logic [1:0] count_r;

      // Load on SET, then count down towards zero while waiting.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_r <= 2'd0;
        end else if (load) begin
          count_r <= value;
        end else if (count_r != 2'd0) begin
          count_r <= count_r - 2'd1;
        end else begin
          count_r <= count_r;
        end
      end

      // Expired one cycle early so the FSM leaves WAIT on the edge the count hits zero.
      assign expired = (count_r == 2'd1);
    end
  endgenerate

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving the B side of a magnitude
// comparator. Optional early exit on equality: define SAR_SEARCH_EARLY_EXIT_EN.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  sar_search_ctrl_if.slave bus
);

  localparam int              IW       = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]   IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_ZERO = IW'(0);
  localparam logic [1:0]      LAT_VAL  = 2'(CMP_LAT);

  sar_state_t       state_r;
  logic [WIDTH-1:0] trial_r;
  logic [WIDTH-1:0] result_r;
  logic [IW-1:0]    idx_r;
  logic             busy_r;
  logic             done_r;
  logic             flag_err_r;

  logic             load_s;
  logic             expired_s;
  logic             early_exit_s;
  logic [WIDTH-1:0] kept_trial_s;
  logic [WIDTH-1:0] next_trial_s;

  assign load_s = (state_r == SET);

  sar_wait_timer #(
    .CMP_LAT (CMP_LAT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .value   (LAT_VAL),
    .expired (expired_s)
  );

`ifdef SAR_SEARCH_EARLY_EXIT_EN
  assign early_exit_s = bus.cmp_eq;
`else
  assign early_exit_s = 1'b0;
`endif

  // Bit decision for the current index, then the next trial with the lower bit set.
  always_comb begin
    kept_trial_s = trial_r;
    next_trial_s = trial_r;
    if (bus.cmp_lt) begin
      kept_trial_s[idx_r] = 1'b0;
    end else begin
      kept_trial_s[idx_r] = trial_r[idx_r];
    end
    next_trial_s = kept_trial_s;
    if (idx_r != IDX_ZERO) begin
      next_trial_s[idx_r - IDX_ONE] = 1'b1;
    end else begin
      next_trial_s[idx_r] = kept_trial_s[idx_r];
    end
  end

  // Search FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      trial_r    <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      idx_r      <= IDX_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      flag_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            trial_r    <= MSB_ONE;
            idx_r      <= IDX_MSB;
            flag_err_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= SET;
          end else begin
            state_r <= IDLE;
          end
        end
        SET: begin
          state_r <= (CMP_LAT > 0) ? WAIT : SAMPLE;
        end
        WAIT: begin
          state_r <= expired_s ? SAMPLE : WAIT;
        end
        SAMPLE: begin
          if (!flags_onehot({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq})) begin
            flag_err_r <= 1'b1;
          end else begin
            flag_err_r <= flag_err_r;
          end
          if (early_exit_s || (idx_r == IDX_ZERO)) begin
            trial_r  <= kept_trial_s;
            result_r <= kept_trial_s;
            state_r  <= DONE;
          end else begin
            trial_r <= next_trial_s;
            idx_r   <= idx_r - IDX_ONE;
            state_r <= SET;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          // A start held high here chains the next search with no idle cycle.
          if (bus.start) begin
            trial_r    <= MSB_ONE;
            idx_r      <= IDX_MSB;
            flag_err_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= SET;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.trial    = trial_r;
  assign bus.result   = result_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.flag_err = flag_err_r;

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller that sits on the operand-B side of a 2-input magnitude comparator (GT/LT/EQ outputs).
- It drives a trial value onto the comparator's B input and consumes the GT/LT/EQ flags. It resolves an unknown operand A, MSB-first, to an exact WIDTH-bit result.
- Used for ADC-style search and threshold discovery wherever a comparator already exists in the datapath.

Parameters:
- WIDTH, 8, bit width of trial and result; legal range 2..16.
- CMP_LAT, 0, clock cycles between a trial update and valid comparator flags; 0 means a purely combinational comparator; legal range 0..3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a search; sampled only in IDLE or DONE.
- cmp_gt  input  1  comparator flag, A > trial.
- cmp_lt  input  1  comparator flag, A < trial.
- cmp_eq  input  1  comparator flag, A == trial.
- trial  output  WIDTH  value driven to the comparator B input; registered.
- busy  output  1  high from the cycle after start is accepted until the search ends.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  resolved value of A; holds until the next accepted start.
- flag_err  output  1  sticky; comparator flags were not one-hot when sampled.

Behaviour:
- Reset (async assert, sync release):
  - trial = 0, result = 0, busy = 0, done = 0, flag_err = 0, state = IDLE.
- States: IDLE, SET, WAIT, SAMPLE, DONE.
- IDLE/DONE + start:
  - bit index i = WIDTH-1.
  - trial = 1 << (WIDTH-1).
  - flag_err cleared; busy = 1; go to SET.
- SET:
  - load wait counter = CMP_LAT.
  - go to WAIT if CMP_LAT > 0, else to SAMPLE.
- WAIT:
  - decrement the counter; go to SAMPLE when it reaches 0.
- SAMPLE (flags taken on this clock edge):
  - if cmp_lt: clear trial[i]; otherwise keep it (gt or eq).
  - if i > 0: set trial[i-1], i = i-1, go to SET.
  - if i == 0: result = final trial, go to DONE.
- DONE:
  - done = 1 for exactly one cycle; busy = 0.
  - trial holds the final value.
  - then IDLE, or SET directly if start is high in DONE (back-to-back searches).
- Latency:
  - start edge to done pulse = WIDTH*(CMP_LAT+2) + 1 cycles.
  - with CMP_LAT=0, WIDTH=8: 17 cycles.
- start while busy is ignored; it is not queued.
- Flag check:
  - in SAMPLE, if {cmp_gt, cmp_lt, cmp_eq} is not exactly one-hot, set flag_err.
  - the bit decision still uses cmp_lt only.
  - flag_err stays set until the next accepted start or reset.
- Boundaries:
  - A = 0 yields 0 (every bit cleared).
  - A = 2^WIDTH-1 yields all ones.
  - trial never exceeds WIDTH bits.
- Reset mid-search: immediate abort to reset values; no done pulse.

Optional Feature:
- Macro: SAR_SEARCH_EARLY_EXIT_EN.
- When defined:
  - in SAMPLE, cmp_eq = 1 ends the search immediately.
  - result = current trial; go to DONE.
  - remaining lower bits stay 0.
  - latency becomes variable, with minimum (CMP_LAT+2)+1 cycles when A = 1 << (WIDTH-1).
- When undefined:
  - cmp_eq only participates in the one-hot check.
  - latency is always the fixed value above.

Decomposition:
- Shared package sar_pkg holds:
  - state enum sar_state_t {IDLE, SET, WAIT, SAMPLE, DONE};
  - a localparam for the flag one-hot check mask.
- One sub-module, sar_wait_timer: small down-counter for CMP_LAT settling.
  - Inputs: load, value. Output: expired.
  - Instantiated once; it is optimised to a wire when CMP_LAT = 0.

Test Plan:
- Bench contents: a behavioural comparator model (A vs trial, with CMP_LAT-cycle registered delay); all cases below use WIDTH = 8.
- Exact resolution: CMP_LAT=0, A = 8'hA5, pulse start -> trial sequence 80, C0, A0, B0, A8, A4, A6, A5; done at cycle 17; result = A5; flag_err = 0.
- Extremes:
  - A = 0 -> result = 00.
  - A = FF -> result = FF.
  - Run both back-to-back with start held high in DONE; no idle cycle between searches.
- Latency with settling: CMP_LAT=2, A = 8'h3C -> done exactly 33 cycles after start; result = 3C; start pulses while busy are ignored.
- Bad flags: model forces gt=1 and lt=1 during bit 5's SAMPLE -> flag_err = 1 and stays set through done; it clears on the next start.
- Reset mid-search: assert rst at cycle 6 of an A = 8'h77 search -> all outputs 0 asynchronously, no done pulse; a fresh start resolves 77.
- Early exit with SAR_SEARCH_EARLY_EXIT_EN, CMP_LAT=0:
  - A = 8'h80 -> done at cycle 3, result = 80.
  - Without the macro, A = 80 -> done at cycle 17.
